instr_sequencer: RTL and testbench

Programmable instruction sequencer that drives the 24-bit `instruction` bus of the `nn` top level. A host preloads a small program of (instruction, hold-count) entries, pulses `start`, and the block replays the program cycle-accurately, holding each instruction for a programmed number of cycles. It then returns the bus to the all-zero idle instruction and pulses `done`. It replaces hand-driven testbench instruction streams as the single upstream source of `nn` control.

---
 rtl/instr_sequencer_if.sv | 29 ++
 rtl/instr_sequencer.sv | 112 +++++++++++
 tb/tb_instr_sequencer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_sequencer_if.sv
// Host-side bus of the instruction sequencer: program load, run control and
// the registered instruction stream toward nn.
interface instr_sequencer_if #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned HOLD_W = 8
);
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [23:0]       prog_instr;
  logic [HOLD_W-1:0] prog_hold;
  logic [ADDR_W:0]   run_len;
  logic              start;
  logic              stop;
  logic [23:0]       instruction;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] pc;

  modport master (
    output prog_we, prog_addr, prog_instr, prog_hold, run_len, start, stop,
    input  instruction, busy, done, pc
  );

  modport slave (
    input  prog_we, prog_addr, prog_instr, prog_hold, run_len, start, stop,
    output instruction, busy, done, pc
  );
endinterface

// File: rtl/instr_sequencer.sv
// Programmable instruction sequencer: replays a preloaded list of
// (instruction, hold) entries onto the nn instruction bus, then idles at zero.
module instr_sequencer #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned HOLD_W = 8
) (
  input logic            clk,
  input logic            rst,
  instr_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

  logic [23:0]       mem_instr [DEPTH];
  logic [HOLD_W-1:0] mem_hold  [DEPTH];

  state_e            state_q;
  logic [23:0]       instr_q;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W-1:0] pc_q;
  logic [HOLD_W-1:0] hold_q;
  logic [ADDR_W:0]   len_q;

  logic [ADDR_W:0]   len_sat;
  logic [ADDR_W:0]   pc_next_ext;
  logic [ADDR_W-1:0] pc_next;

  // Saturate the requested length and form the next entry index.
  always_comb begin
    len_sat     = (bus.run_len > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : bus.run_len;
    pc_next_ext = {1'b0, pc_q} + (ADDR_W+1)'(1);
    pc_next     = pc_next_ext[ADDR_W-1:0];
  end

  // Program storage; writes are locked out while a run is in progress.
  always_ff @(posedge clk) begin
    if (bus.prog_we && !busy_q) begin
      mem_instr[bus.prog_addr] <= bus.prog_instr;
      mem_hold[bus.prog_addr]  <= bus.prog_hold;
    end
  end

  // Sequencer FSM with registered outputs; stop overrides all run transitions.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      instr_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pc_q    <= '0;
      hold_q  <= '0;
      len_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start && !bus.stop) begin
            if (len_sat == '0) begin
              state_q <= StFinish;
              done_q  <= 1'b1;
            end else begin
              state_q <= StRun;
              len_q   <= len_sat;
              pc_q    <= '0;
              hold_q  <= mem_hold[0];
              instr_q <= mem_instr[0];
              busy_q  <= 1'b1;
            end
          end
        end
        StRun: begin
          if (bus.stop) begin
            state_q <= StIdle;
            instr_q <= '0;
            busy_q  <= 1'b0;
            pc_q    <= '0;
            hold_q  <= '0;
          end else if (hold_q != '0) begin
            hold_q <= hold_q - HOLD_W'(1);
          end else if (pc_next_ext < len_q) begin
            pc_q    <= pc_next;
            hold_q  <= mem_hold[pc_next];
            instr_q <= mem_instr[pc_next];
          end else begin
            state_q <= StFinish;
            instr_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pc_q    <= '0;
          end
        end
        StFinish: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          instr_q <= '0;
          busy_q  <= 1'b0;
          pc_q    <= '0;
        end
      endcase
    end
  end

  assign bus.instruction = instr_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pc          = pc_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed vector table plus randomized runs
// compared against an expected-stream model built from the program contents.
module tb_instr_sequencer;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned HOLD_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  instr_sequencer_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .HOLD_W(HOLD_W)) bus ();

  instr_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .HOLD_W(HOLD_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [23:0] instr;
    logic [7:0]  hold;
    logic [4:0]  len;
    logic        start;
    logic        stop;
    logic        rst_n;
    logic [23:0] e_instr;
    logic        e_busy;
    logic        e_done;
    logic [3:0]  e_pc;
  } vec_t;

  typedef struct {
    logic [23:0] instr;
    logic [3:0]  pc;
  } beat_t;

  int total = 0;
  int bad   = 0;
  logic [23:0] ref_instr [DEPTH];
  logic [7:0]  ref_hold  [DEPTH];
  vec_t vecs[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [23:0] ei, input logic eb,
                           input logic ed, input logic [3:0] ep);
    check($sformatf("%s.instr", tag), {8'h0, bus.instruction}, {8'h0, ei});
    check($sformatf("%s.busy", tag), {31'h0, bus.busy}, {31'h0, eb});
    check($sformatf("%s.done", tag), {31'h0, bus.done}, {31'h0, ed});
    check($sformatf("%s.pc", tag), {28'h0, bus.pc}, {28'h0, ep});
  endtask

  task automatic quiet();
    bus.prog_we    = 1'b0;
    bus.prog_addr  = '0;
    bus.prog_instr = '0;
    bus.prog_hold  = '0;
    bus.run_len    = '0;
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
  endtask

  // Idle-time write; the reference copy tracks what the program should hold.
  task automatic write(input logic [3:0] a, input logic [23:0] i, input logic [7:0] h);
    bus.prog_we    = 1'b1;
    bus.prog_addr  = a;
    bus.prog_instr = i;
    bus.prog_hold  = h;
    step();
    bus.prog_we    = 1'b0;
    ref_instr[a]   = i;
    ref_hold[a]    = h;
  endtask

  function automatic vec_t mk(input logic we, input logic [3:0] a, input logic [23:0] i,
                              input logic [7:0] h, input logic [4:0] l, input logic s,
                              input logic p, input logic r, input logic [23:0] ei,
                              input logic eb, input logic ed, input logic [3:0] ep);
    vec_t v;
    v.we = we; v.addr = a; v.instr = i; v.hold = h; v.len = l; v.start = s; v.stop = p;
    v.rst_n = r; v.e_instr = ei; v.e_busy = eb; v.e_done = ed; v.e_pc = ep;
    return v;
  endfunction

  // Expected stream: entry k appears hold_k+1 times, then one done cycle.
  // Optional stop after cycle stop_at; noise writes/starts during the run.
  task automatic run_prog(input string tag, input int len, input bit use_stop, input bit noise);
    beat_t q[$];
    beat_t b;
    int eff;
    int stop_at;
    eff = (len > DEPTH) ? DEPTH : len;
    for (int k = 0; k < eff; k++) begin
      for (int h = 0; h <= int'(ref_hold[k]); h++) begin
        b.instr = ref_instr[k];
        b.pc    = 4'(k);
        q.push_back(b);
      end
    end
    stop_at = (use_stop && q.size() > 0) ? int'($urandom_range(0, q.size() - 1)) : -1;
    bus.run_len = 5'(len);
    bus.start   = 1'b1;
    step();
    quiet();
    for (int i = 0; i < q.size(); i++) begin
      check_out($sformatf("%s.c%0d", tag, i), q[i].instr, 1'b1, 1'b0, q[i].pc);
      if (noise) begin
        bus.prog_we    = 1'($urandom);
        bus.prog_addr  = 4'($urandom);
        bus.prog_instr = 24'($urandom);
        bus.prog_hold  = 8'($urandom);
        bus.start      = 1'($urandom);
        bus.run_len    = 5'($urandom);
      end
      if (i == stop_at) begin
        bus.stop = 1'b1;
        step();
        quiet();
        check_out($sformatf("%s.stop", tag), 24'h0, 1'b0, 1'b0, 4'h0);
        step();
        check_out($sformatf("%s.stop2", tag), 24'h0, 1'b0, 1'b0, 4'h0);
        return;
      end
      step();
    end
    quiet();
    check_out($sformatf("%s.fin", tag), 24'h0, 1'b0, 1'b1, 4'h0);
    step();
    check_out($sformatf("%s.idle", tag), 24'h0, 1'b0, 1'b0, 4'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    // Directed table: programming, basic run, stop, zero length, protection, reset.
    vecs.push_back(mk(1, 0, 24'h100001, 0, 0, 0, 0, 1, 24'h0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 24'h200002, 2, 0, 0, 0, 1, 24'h0, 0, 0, 0));
    vecs.push_back(mk(1, 2, 24'h300003, 0, 0, 0, 0, 1, 24'h0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 24'h0, 0, 3, 1, 0, 1, 24'h100001, 1, 0, 0));
    vecs.push_back(mk(0, 0, 24'h0, 0, 0, 0, 0, 1, 24'h200002, 1, 0, 1));
    vecs.push_back(mk(0, 0, 24'h0, 0, 0, 0, 0, 1, 24'h200002, 1, 0, 1));
    vecs.push_back(mk(0, 0, 24'h0, 0, 0, 0, 0, 1, 24'h200002, 1, 0, 1));
    vecs.push_back(mk(0, 0, 24'h0, 0, 0, 0, 0, 1, 24'h300003, 1, 0, 2));
    vecs.push_back(mk(0, 0, 24'h0, 0, 0, 0, 0, 1, 24'h0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 24'h0, 0, 0, 0, 0, 1, 24'h0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 24'hABCDEF, 10, 0, 0, 0, 1, 24'h0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 24'h0, 0, 1, 1, 0, 1, 24'hABCDEF, 1, 0, 0));
    vecs.push_back(mk(0, 0, 24'h0, 0, 0, 0, 0, 1, 24'hABCDEF, 1, 0, 0));
    vecs.push_back(mk(0, 0, 24'h0, 0, 0, 0, 0, 1, 24'hABCDEF, 1, 0, 0));
    vecs.push_back(mk(0, 0, 24'h0, 0, 0, 0, 1, 1, 24'h0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 24'h0, 0, 0, 0, 0, 1, 24'h0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 24'h0, 0, 1, 1, 1, 1, 24'h0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 24'h0, 0, 0, 1, 0, 1, 24'h0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 24'h0, 0, 0, 0, 0, 1, 24'h0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 24'h100001, 0, 0, 0, 0, 1, 24'h0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 24'h0, 0, 3, 1, 0, 1, 24'h100001, 1, 0, 0));
    vecs.push_back(mk(1, 0, 24'hFFFFFF, 5, 3, 1, 0, 1, 24'h200002, 1, 0, 1));
    vecs.push_back(mk(0, 0, 24'h0, 0, 3, 1, 0, 1, 24'h200002, 1, 0, 1));
    vecs.push_back(mk(0, 0, 24'h0, 0, 0, 0, 0, 1, 24'h200002, 1, 0, 1));
    vecs.push_back(mk(0, 0, 24'h0, 0, 0, 0, 0, 1, 24'h300003, 1, 0, 2));
    vecs.push_back(mk(0, 0, 24'h0, 0, 0, 0, 0, 1, 24'h0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 24'h0, 0, 0, 0, 0, 1, 24'h0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 24'h0, 0, 1, 1, 0, 1, 24'h100001, 1, 0, 0));
    vecs.push_back(mk(0, 0, 24'h0, 0, 0, 0, 0, 1, 24'h0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 24'h0, 0, 0, 0, 0, 1, 24'h0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 24'h0, 0, 3, 1, 0, 1, 24'h100001, 1, 0, 0));
    vecs.push_back(mk(0, 0, 24'h0, 0, 0, 0, 0, 1, 24'h200002, 1, 0, 1));
    vecs.push_back(mk(0, 0, 24'h0, 0, 0, 0, 0, 0, 24'h0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 24'h0, 0, 0, 0, 0, 1, 24'h0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 24'h0, 0, 3, 1, 0, 1, 24'h100001, 1, 0, 0));
    vecs.push_back(mk(0, 0, 24'h0, 0, 0, 0, 0, 1, 24'h200002, 1, 0, 1));
    vecs.push_back(mk(0, 0, 24'h0, 0, 0, 0, 0, 1, 24'h200002, 1, 0, 1));
    vecs.push_back(mk(0, 0, 24'h0, 0, 0, 0, 0, 1, 24'h200002, 1, 0, 1));
    vecs.push_back(mk(0, 0, 24'h0, 0, 0, 0, 0, 1, 24'h300003, 1, 0, 2));
    vecs.push_back(mk(0, 0, 24'h0, 0, 0, 0, 0, 1, 24'h0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 24'h0, 0, 0, 0, 0, 1, 24'h0, 0, 0, 0));

    // Reset with random inputs, then release with no start.
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.prog_we    = 1'($urandom);
      bus.prog_addr  = 4'($urandom);
      bus.prog_instr = 24'($urandom);
      bus.prog_hold  = 8'($urandom);
      bus.run_len    = 5'($urandom);
      bus.start      = 1'($urandom);
      bus.stop       = 1'($urandom);
      step();
      check_out($sformatf("rst%0d", i), 24'h0, 1'b0, 1'b0, 4'h0);
    end
    quiet();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_out($sformatf("post_rst%0d", i), 24'h0, 1'b0, 1'b0, 4'h0);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      bus.prog_we    = vecs[i].we;
      bus.prog_addr  = vecs[i].addr;
      bus.prog_instr = vecs[i].instr;
      bus.prog_hold  = vecs[i].hold;
      bus.run_len    = vecs[i].len;
      bus.start      = vecs[i].start;
      bus.stop       = vecs[i].stop;
      rst            = vecs[i].rst_n;
      step();
      check_out($sformatf("vec%0d", i), vecs[i].e_instr, vecs[i].e_busy, vecs[i].e_done,
                vecs[i].e_pc);
    end
    quiet();
    rst = 1'b1;

    // Full-depth runs with distinct words and zero holds; 31 saturates to 16.
    for (int k = 0; k < DEPTH; k++) write(4'(k), 24'h0A0000 + 24'(k), 8'h0);
    run_prog("len16", 16, 1'b0, 1'b0);
    run_prog("len31", 31, 1'b0, 1'b0);

    // Randomized programs, lengths, noise and occasional stops.
    for (int k = 0; k < DEPTH; k++) write(4'(k), 24'($urandom), 8'($urandom_range(0, 3)));
    for (int it = 0; it < 30; it++) begin
      for (int w = 0; w < int'($urandom_range(0, 4)); w++)
        write(4'($urandom), 24'($urandom), 8'($urandom_range(0, 3)));
      run_prog($sformatf("rnd%0d", it), int'($urandom_range(0, 31)),
               ($urandom_range(0, 3) == 0), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
